mc_clock_gen: RTL and testbench
===============================

Name: mc_clock_gen

Overview:
- Clock source for the simulation cell library.
- Divides a base clock (1 CLK period = 1 redstone tick = 100 ms) into a programmable redstone clock, CLK_OUT, which drives the CLK pins of downstream flip-flop cells.
- Provides free-run and single-step modes, a glitch-free stop that always completes the current period, and a rising-edge counter for benches.
- Sits directly upstream of the library flip-flop cells.

Parameters:
- LEN_W, 8: width of the HIGH_LEN/LOW_LEN inputs.
- CNT_W, 16: width of EDGE_CNT.
- MIN_HIGH, 5: minimum high phase in ticks. Matches the downstream cell clock-capture delay of 5 ticks. Must be ≥1.

Ports:
- CLK  in  1  base clock, one rising edge per redstone tick; all logic is posedge.
- ARST_N  in  1  asynchronous active-low reset.
- RUN  in  1  level; free-run request.
- STEP  in  1  single-cycle pulse; requests exactly one CLK_OUT period when idle.
- HIGH_LEN  in  LEN_W  high-phase length in ticks.
- LOW_LEN  in  LEN_W  low-phase length in ticks.
- CLK_OUT  out  1  generated redstone clock.
- RUNNING  out  1  high whenever the FSM is not IDLE.
- EDGE_CNT  out  CNT_W  count of CLK_OUT rising edges; wraps.

Behaviour:
- Reset (ARST_N=0, asynchronous): state=IDLE, CLK_OUT=0, RUNNING=0, EDGE_CNT=0, phase counter=0. Deassertion takes effect at the next CLK posedge.
- States: IDLE, HIGH, LOW. All outputs are registered.
- Phase lengths:
  - Effective high length Hh = max(HIGH_LEN, MIN_HIGH).
  - Effective low length Ll = max(LOW_LEN, 1).
  - Both lengths are sampled only on entry to HIGH and held for the whole period. Changing them mid-period has no effect until the next period.
- IDLE:
  - If RUN=1 or STEP=1 is sampled at edge n, go to HIGH.
  - CLK_OUT=1 and EDGE_CNT+1 are visible after edge n, so latency is 1 tick.
  - Otherwise stay in IDLE with CLK_OUT=0.
- HIGH: CLK_OUT=1 for exactly Hh ticks, then LOW.
- LOW: CLK_OUT=0 for exactly Ll ticks. On the final low tick:
  - If RUN=1, go to HIGH with a new rising edge, a new sample of lengths, and EDGE_CNT+1.
  - Otherwise go to IDLE.
  - Result: free-run period = Hh+Ll ticks with no gap.
- Stop: RUN dropping during HIGH or LOW never truncates a phase. The current period completes and the FSM then goes to IDLE. No runt pulse is possible.
- STEP outside IDLE is ignored; it is not queued.
- STEP and RUN together in IDLE behave as RUN.
- STEP in IDLE with RUN=0 gives exactly one period (Hh high, Ll low), then IDLE.
- EDGE_CNT increments only on 0→1 transitions of CLK_OUT and wraps from 2^CNT_W−1 to 0.
- RUNNING=1 in HIGH and LOW; it drops in the same tick CLK_OUT returns to IDLE.
- Reset mid-period: CLK_OUT drops to 0 immediately (asynchronously) and the partial period is discarded. EDGE_CNT clears to 0.

Optional Feature:
- Macro MC_CLKGEN_DELAY_EN.
- Defined: CLK_OUT is driven through a transport delay of 1 redstone tick (100 ms), modelling the output torch/repeater. RUNNING and EDGE_CNT are not delayed. Reset still clears the internal register asynchronously, and CLK_OUT follows 1 tick later.
- Undefined: CLK_OUT is driven with zero delay directly from the register.
- Tick counts and latencies above are stated for the undelayed case. With the macro, add exactly 1 tick to every CLK_OUT edge time.

Test Plan:
- Reset and idle: assert ARST_N=0 mid-HIGH → CLK_OUT=0 immediately, RUNNING=0, EDGE_CNT=0. Release with RUN=0 for 20 ticks → CLK_OUT stays 0.
- Free run: HIGH_LEN=6, LOW_LEN=4, RUN=1 from tick 0 → CLK_OUT high ticks 1–6, low 7–10, high 11–16. After 50 ticks, EDGE_CNT=5.
- Clamping: HIGH_LEN=0, LOW_LEN=0, RUN=1 → high 5 ticks, low 1 tick, period 6.
- Graceful stop: HIGH_LEN=6, LOW_LEN=4, drop RUN at tick 3 → period completes; IDLE at tick 11, RUNNING=0, EDGE_CNT=1, no further edges.
- Single step: pulse STEP at tick 0 with RUN=0 → one 6-high/4-low period, EDGE_CNT=1. A second STEP pulse at tick 4 is ignored.
- Length change mid-period and wrap: with CNT_W=2, change HIGH_LEN from 6 to 8 at tick 3 → first high phase still 6 ticks, next high phase 8 ticks. Run 5 periods → EDGE_CNT sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mc_clock_gen.sv
// Programmable redstone clock generator: free-run, single-step, glitch-free stop, edge counter.
// Optional macro MC_CLKGEN_DELAY_EN adds a one-tick transport delay on CLK_OUT only.
module mc_clock_gen #(
    parameter int LEN_W    = 8,
    parameter int CNT_W    = 16,
    parameter int MIN_HIGH = 5
) (
    input  logic             CLK,
    input  logic             ARST_N,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [LEN_W-1:0] HIGH_LEN,
    input  logic [LEN_W-1:0] LOW_LEN,
    output logic             CLK_OUT,
    output logic             RUNNING,
    output logic [CNT_W-1:0] EDGE_CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MINH = LEN_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [LEN_W-1:0] hh_q, hh_d;
    logic [LEN_W-1:0] ll_q, ll_d;
    logic             clk_q, clk_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] hh_s;
    logic [LEN_W-1:0] ll_s;
    logic             enter_high_s;

    // Clamp requested phase lengths to their legal minimums
    always_comb begin
        hh_s = (HIGH_LEN < LEN_MINH) ? LEN_MINH : HIGH_LEN;
        ll_s = (LOW_LEN == LEN_ZERO) ? LEN_ONE : LOW_LEN;
    end

    // Next-state logic; phase_q counts ticks already spent in the current phase
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hh_d         = hh_q;
        ll_d         = ll_q;
        enter_high_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RUN || STEP) begin
                    enter_high_s = 1'b1;
                end else begin
                    phase_d = LEN_ZERO;
                end
            end
            ST_HIGH: begin
                if (phase_q >= hh_q) begin
                    state_d = ST_LOW;
                    phase_d = LEN_ONE;
                end else begin
                    phase_d = phase_q + LEN_ONE;
                end
            end
            ST_LOW: begin
                if (phase_q >= ll_q) begin
                    // A stop request only ever takes effect here, so no phase is truncated
                    if (RUN) begin
                        enter_high_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        phase_d = LEN_ZERO;
                    end
                end else begin
                    phase_d = phase_q + LEN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = LEN_ZERO;
            end
        endcase
        if (enter_high_s) begin
            state_d = ST_HIGH;
            phase_d = LEN_ONE;
            hh_d    = hh_s;
            ll_d    = ll_s;
        end else begin
            hh_d = hh_q;
            ll_d = ll_q;
        end
    end

    // Output decode from the next state so every output is a plain register
    always_comb begin
        clk_d = (state_d == ST_HIGH);
        run_d = (state_d != ST_IDLE);
        if (enter_high_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            phase_q <= LEN_ZERO;
            hh_q    <= LEN_MINH;
            ll_q    <= LEN_ONE;
            clk_q   <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hh_q    <= hh_d;
            ll_q    <= ll_d;
            clk_q   <= clk_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MC_CLKGEN_DELAY_EN
    logic clk_dly_q;

    // Models the output torch/repeater: CLK_OUT trails the internal register by one tick
    always_ff @(posedge CLK) begin
        clk_dly_q <= clk_q;
    end

    assign CLK_OUT = clk_dly_q;
`else
    assign CLK_OUT = clk_q;
`endif

    assign RUNNING  = run_q;
    assign EDGE_CNT = cnt_q;

endmodule

// File: tb/tb_mc_clock_gen.sv
// Directed bench for mc_clock_gen: expected per-tick outputs are queued up front and popped as ticks elapse.
module tb_mc_clock_gen;

    typedef struct {
        logic        clk;
        logic        run;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        ARST_N = 1'b1;
    logic        RUN = 1'b0;
    logic        STEP = 1'b0;
    logic [7:0]  HIGH_LEN = 8'd6;
    logic [7:0]  LOW_LEN = 8'd4;
    logic        clk_out_a, running_a;
    logic [15:0] edge_cnt_a;
    logic        clk_out_b, running_b;
    logic [1:0]  edge_cnt_b;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t e;

    mc_clock_gen #(.LEN_W(8), .CNT_W(16), .MIN_HIGH(5)) u_dut (
        .CLK(CLK), .ARST_N(ARST_N), .RUN(RUN), .STEP(STEP),
        .HIGH_LEN(HIGH_LEN), .LOW_LEN(LOW_LEN),
        .CLK_OUT(clk_out_a), .RUNNING(running_a), .EDGE_CNT(edge_cnt_a)
    );

    // Narrow-counter instance shares all stimulus; used to observe the wrap
    mc_clock_gen #(.LEN_W(8), .CNT_W(2), .MIN_HIGH(5)) u_dut2 (
        .CLK(CLK), .ARST_N(ARST_N), .RUN(RUN), .STEP(STEP),
        .HIGH_LEN(HIGH_LEN), .LOW_LEN(LOW_LEN),
        .CLK_OUT(clk_out_b), .RUNNING(running_b), .EDGE_CNT(edge_cnt_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic c, input logic r, input int n);
        exp_t x;
        x.clk = c;
        x.run = r;
        x.cnt = 16'(n);
        exp_q.push_back(x);
    endtask

    // Advance n ticks, comparing both instances against the queued expectations
    task automatic run_check(input string tag, input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk({tag, "_clk"}, {15'd0, clk_out_a}, {15'd0, x.clk});
                chk({tag, "_running"}, {15'd0, running_a}, {15'd0, x.run});
                chk({tag, "_cnt"}, edge_cnt_a, x.cnt);
                chk({tag, "_clk2"}, {15'd0, clk_out_b}, {15'd0, x.clk});
                chk({tag, "_cnt2"}, {14'd0, edge_cnt_b}, {14'd0, x.cnt[1:0]});
            end
        end
    endtask

    task automatic do_reset();
        RUN = 1'b0;
        STEP = 1'b0;
        ARST_N = 1'b0;
        tick();
        tick();
        ARST_N = 1'b1;
    endtask

    initial begin
        // Initial asynchronous reset
        #2;
        ARST_N = 1'b0;
        #1;
        chk("rst_clk", {15'd0, clk_out_a}, 16'd0);
        chk("rst_running", {15'd0, running_a}, 16'd0);
        chk("rst_cnt", edge_cnt_a, 16'd0);
        tick();
        ARST_N = 1'b1;

        // Free run 6/4: high ticks 1-6, low 7-10, repeating; 5 edges after 50 ticks
        HIGH_LEN = 8'd6;
        LOW_LEN = 8'd4;
        RUN = 1'b1;
        for (int j = 0; j < 51; j++) push((j % 10) < 6, 1'b1, j / 10 + 1);
        run_check("freerun", 51);

        // Reset mid-HIGH: outputs clear without waiting for a clock edge
        ARST_N = 1'b0;
        #1;
        chk("midrst_clk", {15'd0, clk_out_a}, 16'd0);
        chk("midrst_running", {15'd0, running_a}, 16'd0);
        chk("midrst_cnt", edge_cnt_a, 16'd0);
        chk("midrst_cnt2", {14'd0, edge_cnt_b}, 16'd0);
        RUN = 1'b0;
        tick();
        ARST_N = 1'b1;
        for (int j = 0; j < 20; j++) push(1'b0, 1'b0, 0);
        run_check("idle", 20);

        // Clamping: zero lengths give 5 high / 1 low
        do_reset();
        HIGH_LEN = 8'd0;
        LOW_LEN = 8'd0;
        RUN = 1'b1;
        for (int j = 0; j < 24; j++) push((j % 6) < 5, 1'b1, j / 6 + 1);
        run_check("clamp", 24);

        // Graceful stop: RUN drops at tick 3, period still completes, idle from tick 11
        do_reset();
        HIGH_LEN = 8'd6;
        LOW_LEN = 8'd4;
        RUN = 1'b1;
        for (int j = 0; j < 25; j++) push(j < 6, j < 10, 1);
        run_check("stop", 3);
        RUN = 1'b0;
        run_check("stop", 22);

        // Single step with a second STEP at tick 4 that must be ignored
        do_reset();
        STEP = 1'b1;
        for (int j = 0; j < 25; j++) push(j < 6, j < 10, 1);
        run_check("step", 1);
        STEP = 1'b0;
        run_check("step", 3);
        STEP = 1'b1;
        run_check("step", 1);
        STEP = 1'b0;
        run_check("step", 20);

        // Length change mid-period takes effect next period; 2-bit counter wraps 1,2,3,0,1
        do_reset();
        HIGH_LEN = 8'd6;
        LOW_LEN = 8'd4;
        RUN = 1'b1;
        for (int j = 0; j < 58; j++) begin
            if (j < 10) push(j < 6, 1'b1, 1);
            else push(((j - 10) % 12) < 8, 1'b1, (j - 10) / 12 + 2);
        end
        run_check("lenchg", 3);
        HIGH_LEN = 8'd8;
        run_check("lenchg", 55);

        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
